// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive safety monitor for a two-head traffic light controller. It tracks
//   each head's phase from its lamp outputs and flags illegal lamp patterns,
//   illegal phase order, short green/yellow dwell and cross-head conflict.
//   The first fault after reset or clr is latched until cleared.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   r1/y1/g1     head-1 lamps
//   r2/y2/g2     head-2 lamps
//   clr          synchronous pulse, clears the sticky fault
//   fault        sticky fault flag
//   fault_code   first fault: 0 none, 1 CONFLICT, 2 LAMP, 3 SEQ, 4 SHORT
//   fault_head   head mask of the first fault (bit0 = head1, bit1 = head2)
//   head1_st     head-1 phase: 0 UNK, 1 RED, 2 YEL, 3 GRN
//   head2_st     head-2 phase, same encoding
//   phase_cnt    completed head-1 cycles (legal YEL->RED), wraps 255 -> 0
module traffic_light_monitor #(
  parameter int unsigned CW      = 8,
  parameter int unsigned GRN_MIN = 4,
  parameter int unsigned YEL_MIN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r1,
  input  logic       y1,
  input  logic       g1,
  input  logic       r2,
  input  logic       y2,
  input  logic       g2,
  input  logic       clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_head,
  output logic [1:0] head1_st,
  output logic [1:0] head2_st,
  output logic [7:0] phase_cnt
);

  // Phase encoding; bit1 set means YEL or GRN (the "moving traffic" phases).
  localparam logic [1:0] ST_UNK = 2'd0;
  localparam logic [1:0] ST_RED = 2'd1;
  localparam logic [1:0] ST_YEL = 2'd2;
  localparam logic [1:0] ST_GRN = 2'd3;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_LAMP     = 3'd2;
  localparam logic [2:0] FC_SEQ      = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;

  localparam logic [CW-1:0] DWELL_ONE = CW'(1);
  localparam logic [CW-1:0] DWELL_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] GRN_MIN_W = CW'(GRN_MIN);
  localparam logic [CW-1:0] YEL_MIN_W = CW'(YEL_MIN);

  logic [2:0]    lamps   [2];
  logic [1:0]    lamp_st [2];
  logic [1:0]    st_q    [2];
  logic [1:0]    st_d    [2];
  logic [CW-1:0] dwell_q [2];
  logic [CW-1:0] dwell_d [2];
  logic [1:0]    lamp_err;
  logic [1:0]    seq_err;
  logic [1:0]    short_err;
  logic          conflict;
  logic          cycle_done;
  logic          new_any;
  logic [2:0]    new_code;
  logic [1:0]    new_head;

  assign lamps[0] = {r1, y1, g1};
  assign lamps[1] = {r2, y2, g2};

  // Per-head decode, phase update and transition checks.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      lamp_st[h]   = ST_UNK;
      st_d[h]      = st_q[h];
      dwell_d[h]   = dwell_q[h];
      seq_err[h]   = 1'b0;
      short_err[h] = 1'b0;

      case (lamps[h])
        3'b100:  lamp_st[h] = ST_RED;
        3'b010:  lamp_st[h] = ST_YEL;
        3'b001:  lamp_st[h] = ST_GRN;
        default: lamp_st[h] = ST_UNK;
      endcase
      // Dark or multi-lamp pattern: fault, state and dwell held.
      lamp_err[h] = (lamp_st[h] == ST_UNK);

      if (!lamp_err[h]) begin
        if (lamp_st[h] == st_q[h]) begin
          if (dwell_q[h] != DWELL_MAX) dwell_d[h] = dwell_q[h] + 1'b1;
        end else begin
          // Illegal order is still followed so the monitor re-locks onto
          // whatever the controller is actually showing.
          st_d[h]    = lamp_st[h];
          dwell_d[h] = DWELL_ONE;
          if (st_q[h] != ST_UNK) begin
            seq_err[h]   = !((st_q[h] == ST_RED && lamp_st[h] == ST_GRN) ||
                             (st_q[h] == ST_GRN && lamp_st[h] == ST_YEL) ||
                             (st_q[h] == ST_YEL && lamp_st[h] == ST_RED));
            short_err[h] = (st_q[h] == ST_GRN && lamp_st[h] == ST_YEL &&
                            dwell_q[h] < GRN_MIN_W) ||
                           (st_q[h] == ST_YEL && lamp_st[h] == ST_RED &&
                            dwell_q[h] < YEL_MIN_W);
          end
        end
      end
    end

    conflict   = !lamp_err[0] && !lamp_err[1] &&
                 lamp_st[0][1] && lamp_st[1][1];
    cycle_done = (st_q[0] == ST_YEL) && (lamp_st[0] == ST_RED);
  end

  // Fault priority: CONFLICT > LAMP > SEQ > SHORT.
  always_comb begin
    new_code = FC_NONE;
    new_head = 2'b00;
    if (conflict) begin
      new_code = FC_CONFLICT;
      new_head = 2'b11;
    end else if (|lamp_err) begin
      new_code = FC_LAMP;
      new_head = lamp_err;
    end else if (|seq_err) begin
      new_code = FC_SEQ;
      new_head = seq_err;
    end else if (|short_err) begin
      new_code = FC_SHORT;
      new_head = short_err;
    end
    new_any = (new_code != FC_NONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-head state arrays are tiny control registers, not a
      // RAM, so they are reset along with everything else.
      for (int h = 0; h < 2; h++) begin
        st_q[h]    <= ST_UNK;
        dwell_q[h] <= '0;
      end
      phase_cnt <= 8'd0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        st_q[h]    <= st_d[h];
        dwell_q[h] <= dwell_d[h];
      end
      if (cycle_done) phase_cnt <= phase_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      fault_head <= 2'b00;
    end else if (clr) begin
      // Set wins over clear; with no new fault this returns all to zero.
      fault      <= new_any;
      fault_code <= new_code;
      fault_head <= new_head;
    end else if (new_any && !fault) begin
      fault      <= 1'b1;
      fault_code <= new_code;
      fault_head <= new_head;
    end
  end

  assign head1_st = st_q[0];
  assign head2_st = st_q[1];

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
//   Directed scoreboard bench for traffic_light_monitor. Each stimulus step
//   drives lamps on the falling edge and queues the hand-computed outputs
//   expected after the next rising edge; a monitor process pops and compares
//   one entry per rising edge.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       r1, y1, g1, r2, y2, g2, clr;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_head, head1_st, head2_st;
  logic [7:0] phase_cnt;

  typedef struct packed {
    logic       f;
    logic [2:0] code;
    logic [1:0] head;
    logic [1:0] h1;
    logic [1:0] h2;
    logic [7:0] pc;
  } obs_t;

  typedef struct {
    bit    care;
    obs_t  exp;
    string name;
  } sb_t;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] GY  = 3'b011;

  sb_t  q[$];
  obs_t act;
  int   checks   = 0;
  int   failures = 0;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .r1         (r1),
    .y1         (y1),
    .g1         (g1),
    .r2         (r2),
    .y2         (y2),
    .g2         (g2),
    .clr        (clr),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_head (fault_head),
    .head1_st   (head1_st),
    .head2_st   (head2_st),
    .phase_cnt  (phase_cnt)
  );

  always #5 clk = ~clk;

  assign act = {fault, fault_code, fault_head, head1_st, head2_st, phase_cnt};

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  function automatic obs_t ob(input logic f, input logic [2:0] code,
                              input logic [1:0] head, input logic [1:0] h1,
                              input logic [1:0] h2, input logic [7:0] pc);
    return '{f: f, code: code, head: head, h1: h1, h2: h2, pc: pc};
  endfunction

  task automatic step(input string name, input logic [2:0] l1,
                      input logic [2:0] l2, input logic c, input obs_t e);
    sb_t s;
    @(negedge clk);
    {r1, y1, g1} = l1;
    {r2, y2, g2} = l2;
    clr = c;
    s.care = 1'b1;
    s.exp  = e;
    s.name = name;
    q.push_back(s);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(q.size()), 32'd0);
  endtask

  // Monitor: one expected entry per rising edge, sampled 1 unit after it.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        if (e.care) check(e.name, 32'(act), 32'(e.exp));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {r1, y1, g1, r2, y2, g2, clr} = '0;
    #12;
    check("reset_state", 32'(act), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Legal head-1 cycle G(5) Y(2) R with head 2 red throughout.
    for (int i = 0; i < 5; i++) step("legal_g", G, R, 0, ob(0, 0, 0, 3, 1, 0));
    step("legal_y1", Y, R, 0, ob(0, 0, 0, 2, 1, 0));
    step("legal_y2", Y, R, 0, ob(0, 0, 0, 2, 1, 0));
    step("legal_r",  R, R, 0, ob(0, 0, 0, 1, 1, 1));

    // Short green: 2 cycles then yellow.
    step("short_g1", G, R, 0, ob(0, 0, 0, 3, 1, 1));
    step("short_g2", G, R, 0, ob(0, 0, 0, 3, 1, 1));
    step("short_y",  Y, R, 0, ob(1, 4, 2'b01, 2, 1, 1));
    step("clr_legal", Y, R, 1, ob(0, 0, 0, 2, 1, 1));
    step("after_clr_r", R, R, 0, ob(0, 0, 0, 1, 1, 2));

    // Double lamp on head 1; state holds GRN.
    step("lamp_pre_g", G, R, 0, ob(0, 0, 0, 3, 1, 2));
    step("lamp_gy",    GY, R, 0, ob(1, 2, 2'b01, 3, 1, 2));
    step("lamp_sticky", G, R, 0, ob(1, 2, 2'b01, 3, 1, 2));
    step("clr_before_conf", G, R, 1, ob(0, 0, 0, 3, 1, 2));

    // Head 2 RED->YEL (SEQ) while head 1 GRN: CONFLICT wins.
    step("conflict", G, Y, 0, ob(1, 1, 2'b11, 3, 2, 2));
    // Head 2 short yellow: new fault ignored, first fault retained.
    step("sticky_first", G, R, 0, ob(1, 1, 2'b11, 3, 1, 2));
    // clr coincident with head-1 GRN->RED: set wins, SEQ captured.
    step("clr_set_wins", R, R, 1, ob(1, 3, 2'b01, 1, 1, 2));
    step("clr_rr", R, R, 1, ob(0, 0, 0, 1, 1, 2));
    // Both heads dark on the same edge: same-type fault on both heads.
    step("lamp_both", OFF, OFF, 0, ob(1, 2, 2'b11, 1, 1, 2));
    step("clr_both", R, R, 1, ob(0, 0, 0, 1, 1, 2));

    // Walk into yellow, then reset asynchronously mid-yellow.
    for (int i = 0; i < 4; i++) step("pre_rst_g", G, R, 0, ob(0, 0, 0, 3, 1, 2));
    step("pre_rst_y", Y, R, 0, ob(0, 0, 0, 2, 1, 2));
    drain();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", 32'(act), 32'd0);
    {r1, y1, g1} = R;
    {r2, y2, g2} = R;
    clr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // After reset RED is accepted without an order check.
    step("post_rst_r", R, R, 0, ob(0, 0, 0, 1, 1, 0));

    // 256 legal cycles R->G(4)->Y(2)->R; phase_cnt wraps back to 0.
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 4; i++)
        step($sformatf("wrap_g_%0d", k), G, R, 0, ob(0, 0, 0, 3, 1, 8'(k)));
      for (int i = 0; i < 2; i++)
        step($sformatf("wrap_y_%0d", k), Y, R, 0, ob(0, 0, 0, 2, 1, 8'(k)));
      step($sformatf("wrap_r_%0d", k), R, R, 0, ob(0, 0, 0, 1, 1, 8'(k + 1)));
    end
    drain();
    check("wrap_final_cnt", 32'(phase_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive safety monitor on the lamp outputs (r1,y1,g1,r2,y2,g2) of the two-head traffic light controller.
- Tracks each head's phase and checks for illegal lamp patterns, illegal phase order, short green/yellow dwell and cross-head conflict.
- Latches the first fault for the test harness or a system-level shutdown.
- Does not drive the controller.

Parameters:
- CW, 8, width of the per-head dwell counters (saturating).
- GRN_MIN, 4, minimum consecutive sampled cycles in green before yellow.
- YEL_MIN, 2, minimum consecutive sampled cycles in yellow before red.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- r1 / y1 / g1  in  1 each  head-1 lamps.
- r2 / y2 / g2  in  1 each  head-2 lamps.
- clr  in  1  synchronous pulse; clears the sticky fault.
- fault  out  1  sticky fault flag.
- fault_code  out  3  first fault: 0 none, 1 CONFLICT, 2 LAMP, 3 SEQ, 4 SHORT.
- fault_head  out  2  head mask of the first fault (bit0 = head1, bit1 = head2).
- head1_st  out  2  head-1 phase: 0 UNK, 1 RED, 2 YEL, 3 GRN.
- head2_st  out  2  head-2 phase, same encoding.
- phase_cnt  out  8  completed head-1 cycles, wraps 255 -> 0.

Behaviour:
- Reset (async, any time): head states UNK, dwell counters 0, fault 0, fault_code 0, fault_head 0, phase_cnt 0.
  - Reset mid-operation discards all history; the next valid lamp pattern is accepted without an order check.
- Sampling: all checks evaluate the lamp inputs present at a rising edge against the stored state.
  - Results are registered at that same edge, so outputs are visible the cycle after the sampled edge.
- Per-head decode:
  - Exactly one of r/y/g high gives RED/YEL/GRN.
  - Zero or more than one high is a LAMP fault for that head; its state and dwell are held.
- Per-head state machine:
  - From UNK, any valid lamp enters that state with dwell = 1.
  - Legal transitions are RED->GRN, GRN->YEL and YEL->RED.
  - Same lamp: dwell increments, saturating at 2^CW-1.
  - Legal change: state updates, dwell = 1.
  - Illegal change (GRN->RED, RED->YEL, YEL->GRN): SEQ fault; the state still updates to the new lamp, dwell = 1.
- Dwell check, on the edge where the transition is seen:
  - GRN->YEL with old dwell < GRN_MIN: SHORT fault.
  - YEL->RED with old dwell < YEL_MIN: SHORT fault.
  - The state update proceeds normally.
- Conflict: decoded valid lamps of both heads in {YEL, GRN} on the same edge gives a CONFLICT fault with fault_head = 2'b11.
- phase_cnt increments on each legal head-1 YEL->RED transition.
- Fault capture:
  - fault is sticky.
  - fault_code / fault_head record only the first fault after reset or clr.
  - Simultaneous faults on one edge resolve by priority CONFLICT > LAMP > SEQ > SHORT.
  - For a same-type fault on both heads, fault_head = 2'b11.
- clr:
  - clr with no new fault on that edge returns fault, fault_code and fault_head to 0.
  - clr on the same edge as a new fault: the new fault is captured (set wins).
  - clr does not touch head states, dwell or phase_cnt.

Test Plan:
- Reset, then head1 G(5)->Y(2)->R and head2 R throughout -> fault stays 0, head1_st sequence 3,2,1, phase_cnt = 1.
- head1 G for 2 cycles then Y (GRN_MIN = 4) -> one cycle after the Y edge: fault = 1, fault_code = 4, fault_head = 01.
- g1 = 1 and y1 = 1 for one cycle -> fault_code = 2, fault_head = 01; head1_st holds GRN.
- head1 GRN, head2 goes YEL while a head2 SEQ (RED->YEL) also occurs -> fault_code = 1 (CONFLICT wins), fault_head = 11.
- After a fault, pulse clr with legal lamps -> fault = 0 and fault_code = 0 next cycle. Repeat with clr coincident with a G->R transition -> fault = 1, fault_code = 3.
- Assert rst mid-yellow -> outputs 0 immediately (asynchronous). Then present R after reset -> head1_st = 1 with no SEQ fault. Run 256 legal cycles -> phase_cnt wraps to 0.
